spart_driver: RTL and testbench
===============================

Name: spart_driver

Overview:
- Bus-master controller that configures and sequences one SPART over its 8-bit shared-bus interface.
- After reset it programs the 16-bit baud divisor from board switches, then runs an echo loop: it reads every received byte and writes it back to the transmitter.
- It sits between the board switches and the SPART, and is the only master on the SPART databus.

Parameters:
- DIV_4800, 16'h028A, divisor written when br_cfg = 2'b00
- DIV_9600, 16'h0145, divisor written when br_cfg = 2'b01
- DIV_19200, 16'h00A2, divisor written when br_cfg = 2'b10
- DIV_38400, 16'h0050, divisor written when br_cfg = 2'b11

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- br_cfg  input  2  baud select switches, asynchronous to clk
- iocs  output  1  SPART chip select
- iorw  output  1  1 = read (SPART drives bus), 0 = write (driver drives bus)
- ioaddr  output  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- databus  inout  8  shared bidirectional data bus
- cfg_done  output  1  high once the divisor is programmed; low during reprogramming
- echo_cnt  output  8  count of bytes echoed, wraps 8'hFF -> 8'h00

Behaviour:
- Reset (rst = 0), asynchronous:
  - state = INIT, init counter = 0, hold = 8'h00, echo_cnt = 0, cfg_done = 0.
  - iocs = 0, iorw = 1, ioaddr = 2'b00, databus = Z.
  - Reset asserted mid-cycle aborts the access immediately; no partial writes are retried.
- Clock domain and bus drive:
  - br_cfg passes through a 2-flop synchronizer.
  - Bus outputs are a Moore decode of the state register; each bus access lasts exactly one clk cycle.
  - databus is driven only when iocs = 1 and iorw = 0; otherwise it is Z.
- INIT: held 2 cycles for synchronizer settle, then -> CFG_LO.
- CFG_LO: iocs = 1, iorw = 0, ioaddr = 10, databus = selected divisor [7:0]. Latch the selected br_cfg into cfg_sel. -> CFG_HI.
- CFG_HI: iocs = 1, iorw = 0, ioaddr = 11, databus = divisor [15:8]. -> IDLE; cfg_done = 1 from the next cycle.
- First IDLE cycle is the 5th rising edge after reset deassertion.
- IDLE: iocs = 0. Priority order:
  1. synchronized br_cfg != cfg_sel: cfg_done = 0, -> CFG_LO.
  2. rda = 1: -> RD.
  3. otherwise stay in IDLE.
- RD: iocs = 1, iorw = 1, ioaddr = 00. Sample databus into hold on the rising edge that ends the cycle. -> WAIT_TX.
- WAIT_TX: iocs = 0.
  - rda and br_cfg changes are ignored.
  - If tbr = 1, -> WR; otherwise wait indefinitely.
- WR: iocs = 1, iorw = 0, ioaddr = 00, databus = hold (after the optional transform). echo_cnt += 1. -> IDLE.
- Latency:
  - rda seen in IDLE to RD: 1 cycle.
  - rda in IDLE with tbr already 1: RD, WAIT_TX, WR occupy cycles 1, 2, 3 after detection.
- Boundary conditions:
  - rda asserted on the same edge a br_cfg change is detected: reconfiguration wins; the byte is serviced after CFG_HI.
  - rda still high in the IDLE cycle after WR (SPART not yet cleared it) triggers another RD. The SPART is responsible for deasserting rda within one cycle of its read.
- Status register (ioaddr 01) is never accessed; status comes from the rda/tbr pins.

Optional Feature:
- Macro: ECHO_UPCASE_EN.
- Defined: in WR, a hold byte in 8'h61..8'h7A is driven as hold - 8'h20 (lowercase ASCII to uppercase). All other bytes pass unchanged.
- Undefined: hold is driven unmodified.
- State sequence and timing are identical in both builds.

Test Plan:
- br_cfg = 01, release reset -> cycle 3 writes 8'h45 at ioaddr 10, cycle 4 writes 8'h01 at ioaddr 11, cfg_done = 1 at cycle 5, bus Z otherwise.
- Model SPART presents 8'h41 with rda pulse, tbr = 1 -> one RD cycle, then WR drives 8'h41 at ioaddr 00 two cycles later, echo_cnt = 1.
- Byte 8'h62 with tbr held 0 for 20 cycles -> driver stays in WAIT_TX with iocs = 0. WR happens 1 cycle after tbr rises and drives 8'h42 with ECHO_UPCASE_EN, 8'h62 without.
- Change br_cfg 01 -> 11 while idle -> cfg_done drops, writes 8'h50 then 8'h00, cfg_done returns; rda asserted during reconfiguration is serviced afterwards.
- Assert rst during WR -> databus goes Z and iocs = 0 immediately; after release the full configuration sequence repeats and echo_cnt = 0.
- Echo 256 bytes -> echo_cnt wraps to 8'h00; no bus contention (driver never drives while iorw = 1).

Source files
------------

// File: rtl/spart_driver_if.sv
// Control/status signals between spart_driver (master) and the SPART (slave).
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg_i, then echoes each received byte (RD, wait tbr, WR).
// One clk per bus access; stalls in WAIT_TX while tbr is low. ECHO_UPCASE_EN uppercases echoed lowercase ASCII.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'h028A,
    parameter logic [15:0] DIV_9600  = 16'h0145,
    parameter logic [15:0] DIV_19200 = 16'h00A2,
    parameter logic [15:0] DIV_38400 = 16'h0050
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     br_cfg_i,
    spart_driver_if.master sp,
    inout  wire  [7:0]     databus_io,
    output logic           cfg_done_o,
    output logic [7:0]     echo_cnt_o
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CFG_LO,
        ST_CFG_HI,
        ST_IDLE,
        ST_RD,
        ST_WAIT_TX,
        ST_WR
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] init_cnt_q, init_cnt_d;
    logic [1:0] br_meta_q, br_sync_q;
    logic [1:0] cfg_sel_q, cfg_sel_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] echo_cnt_q, echo_cnt_d;
    logic       cfg_done_q, cfg_done_d;

    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] bus_dat;
    logic [7:0] echo_dat;

    function automatic logic [7:0] div_byte(input logic [1:0] sel, input logic hi);
        logic [15:0] d;
        case (sel)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return hi ? d[15:8] : d[7:0];
    endfunction

`ifdef ECHO_UPCASE_EN
    assign echo_dat = (hold_q >= 8'h61 && hold_q <= 8'h7A) ? (hold_q - 8'h20) : hold_q;
`else
    assign echo_dat = hold_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_meta_q <= 2'b00;
            br_sync_q <= 2'b00;
        end else begin
            br_meta_q <= br_cfg_i;
            br_sync_q <= br_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 2'd0;
            cfg_sel_q  <= 2'b00;
            hold_q     <= 8'h00;
            echo_cnt_q <= 8'h00;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cfg_sel_q  <= cfg_sel_d;
            hold_q     <= hold_d;
            echo_cnt_q <= echo_cnt_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cfg_sel_d  = cfg_sel_q;
        hold_d     = hold_q;
        echo_cnt_d = echo_cnt_q;
        cfg_done_d = cfg_done_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == 2'd2) state_d = ST_CFG_LO;
                else                    init_cnt_d = init_cnt_q + 2'd1;
            end
            ST_CFG_LO: begin
                cfg_sel_d = br_sync_q;
                state_d   = ST_CFG_HI;
            end
            ST_CFG_HI: begin
                cfg_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                // A pending switch change outranks a waiting byte.
                if (br_sync_q != cfg_sel_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = ST_CFG_LO;
                end else if (sp.rda) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                hold_d  = databus_io;
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (sp.tbr) state_d = ST_WR;
            end
            ST_WR: begin
                echo_cnt_d = echo_cnt_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Bus outputs decode the state register only, so reset idles the bus at once.
    always_comb begin
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        bus_dat = 8'h00;
        case (state_q)
            ST_CFG_LO: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b10;
                bus_dat = div_byte(br_sync_q, 1'b0);
            end
            ST_CFG_HI: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b11;
                bus_dat = div_byte(cfg_sel_q, 1'b1);
            end
            ST_RD: begin
                iocs = 1'b1;
            end
            ST_WR: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                bus_dat = echo_dat;
            end
            default: ;
        endcase
    end

    assign sp.iocs    = iocs;
    assign sp.iorw    = iorw;
    assign sp.ioaddr  = ioaddr;
    assign databus_io = (iocs && !iorw) ? bus_dat : 8'hzz;

    assign cfg_done_o = cfg_done_q;
    assign echo_cnt_o = echo_cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: table-driven config/echo vectors, hand sequences for corner cases, random echoes vs a reference model.
module tb_spart_driver;

`ifdef ECHO_UPCASE_EN
    localparam bit UPC = 1'b1;
`else
    localparam bit UPC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       cfg_done;
    logic [7:0] echo_cnt;
    logic [7:0] rx_byte;
    wire  [7:0] databus;

    spart_driver_if sp_if ();

    spart_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg_i   (br_cfg),
        .sp         (sp_if),
        .databus_io (databus),
        .cfg_done_o (cfg_done),
        .echo_cnt_o (echo_cnt)
    );

    // SPART side of the bus: drives the RX byte only while the driver reads.
    assign databus = (sp_if.iocs && sp_if.iorw) ? rx_byte : 8'hzz;

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] br; logic [7:0] lo; logic [7:0] hi; } cfg_vec_t;
    typedef struct packed { logic [7:0] din; logic [7:0] dout; logic [4:0] dly; } echo_vec_t;

    cfg_vec_t    cv [4];
    echo_vec_t   ev [9];
    logic [15:0] div_tab [4];
    logic [1:0]  cur_br;
    logic [7:0]  exp_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [7:0] ref_echo(input logic [7:0] b);
        if (UPC && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic expect_bus(input string nm, input bit cs, input bit rw, input logic [1:0] a,
                              input logic [7:0] d, input bit done);
        logic [12:0] act, want;
        logic [7:0]  ad;
        ad = (sp_if.iocs && !sp_if.iorw) ? databus : 8'h00;
        if (cs) begin
            act  = {sp_if.iocs, sp_if.iorw, sp_if.ioaddr, ad, cfg_done};
            want = {1'b1, rw, a, rw ? 8'h00 : d, done};
        end else begin
            act  = {sp_if.iocs, 11'h000, cfg_done};
            want = {1'b0, 11'h000, done};
        end
        chk(nm, 32'(act), 32'(want));
    endtask

    task automatic expect_reset(input string nm);
        chk(nm, 32'({sp_if.iocs, sp_if.iorw, sp_if.ioaddr, cfg_done, echo_cnt}),
                32'({1'b0, 1'b1, 2'b00, 1'b0, 8'h00}));
    endtask

    task automatic reset_cfg(input logic [1:0] br, input logic [7:0] lo, input logic [7:0] hi);
        br_cfg    = br;
        rst       = 1'b0;
        sp_if.rda = 1'b0;
        sp_if.tbr = 1'b0;
        @(negedge clk);
        expect_reset("reset_state");
        rst = 1'b1;
        @(negedge clk); expect_bus("init_c1", 0, 1, 2'b00, 8'h00, 0);
        @(negedge clk); expect_bus("init_c2", 0, 1, 2'b00, 8'h00, 0);
        @(negedge clk); expect_bus("cfg_lo",  1, 0, 2'b10, lo, 0);
        @(negedge clk); expect_bus("cfg_hi",  1, 0, 2'b11, hi, 0);
        @(negedge clk); expect_bus("cfg_idle", 0, 1, 2'b00, 8'h00, 1);
        chk("cnt_after_cfg", 32'(echo_cnt), 32'h0);
        cur_br  = br;
        exp_cnt = 8'h00;
    endtask

    // Starts one negedge before the RD cycle; ends at the negedge of the IDLE cycle after WR.
    task automatic service(input logic [7:0] dout, input int dly, input bit keep);
        bit stayed;
        @(negedge clk); expect_bus("rd", 1, 1, 2'b00, 8'h00, 1);
        if (!keep) sp_if.rda = 1'b0;
        if (dly == 0) begin
            @(negedge clk); expect_bus("wait_tx", 0, 1, 2'b00, 8'h00, 1);
        end else begin
            stayed = 1'b1;
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                if (sp_if.iocs !== 1'b0) stayed = 1'b0;
            end
            chk("wait_tx_hold", 32'(stayed), 32'h1);
            sp_if.tbr = 1'b1;
        end
        @(negedge clk); expect_bus("wr", 1, 0, 2'b00, dout, 1);
        exp_cnt = exp_cnt + 8'd1;
        @(negedge clk); expect_bus("post_wr_idle", 0, 1, 2'b00, 8'h00, 1);
        chk("echo_cnt", 32'(echo_cnt), 32'(exp_cnt));
    endtask

    task automatic echo(input logic [7:0] din, input logic [7:0] dout, input int dly);
        rx_byte   = din;
        sp_if.rda = 1'b1;
        sp_if.tbr = (dly == 0);
        service(dout, dly, 1'b0);
    endtask

    task automatic reconfig(input logic [1:0] br, input bit with_rda, input logic [7:0] din);
        logic [15:0] d;
        d      = div_tab[br];
        br_cfg = br;
        @(negedge clk); expect_bus("rc_sync1", 0, 1, 2'b00, 8'h00, 1);
        @(negedge clk); expect_bus("rc_sync2", 0, 1, 2'b00, 8'h00, 1);
        if (with_rda) begin
            rx_byte   = din;
            sp_if.rda = 1'b1;
            sp_if.tbr = 1'b1;
        end
        @(negedge clk); expect_bus("rc_lo",   1, 0, 2'b10, d[7:0], 0);
        @(negedge clk); expect_bus("rc_hi",   1, 0, 2'b11, d[15:8], 0);
        @(negedge clk); expect_bus("rc_idle", 0, 1, 2'b00, 8'h00, 1);
        cur_br = br;
        if (with_rda) service(ref_echo(din), 0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [1:0] nb;

        div_tab[0] = 16'h028A;
        div_tab[1] = 16'h0145;
        div_tab[2] = 16'h00A2;
        div_tab[3] = 16'h0050;

        cv[0] = '{2'b00, 8'h8A, 8'h02};
        cv[1] = '{2'b10, 8'hA2, 8'h00};
        cv[2] = '{2'b11, 8'h50, 8'h00};
        cv[3] = '{2'b01, 8'h45, 8'h01};

        ev[0] = '{8'h41, 8'h41, 5'd0};
        ev[1] = '{8'h62, UPC ? 8'h42 : 8'h62, 5'd20};
        ev[2] = '{8'h61, UPC ? 8'h41 : 8'h61, 5'd0};
        ev[3] = '{8'h7A, UPC ? 8'h5A : 8'h7A, 5'd2};
        ev[4] = '{8'h60, 8'h60, 5'd0};
        ev[5] = '{8'h7B, 8'h7B, 5'd1};
        ev[6] = '{8'h00, 8'h00, 5'd0};
        ev[7] = '{8'hFF, 8'hFF, 5'd3};
        ev[8] = '{8'h5A, 8'h5A, 5'd0};

        rst       = 1'b0;
        br_cfg    = 2'b00;
        rx_byte   = 8'h00;
        sp_if.rda = 1'b0;
        sp_if.tbr = 1'b0;
        cur_br    = 2'b00;
        exp_cnt   = 8'h00;

        for (int i = 0; i < 4; i++) reset_cfg(cv[i].br, cv[i].lo, cv[i].hi);

        for (int i = 0; i < 9; i++) echo(ev[i].din, ev[i].dout, int'(ev[i].dly));

        // rda left high through WR re-triggers a read.
        rx_byte   = 8'h10;
        sp_if.rda = 1'b1;
        sp_if.tbr = 1'b1;
        service(8'h10, 0, 1'b1);
        rx_byte = 8'h7A;
        service(ref_echo(8'h7A), 0, 1'b0);

        // Switch change with rda raised on the detection edge: config first, then the byte.
        reconfig(2'b11, 1'b1, 8'h6D);

        // Reset during WR idles the bus immediately and restarts configuration.
        rx_byte   = 8'h33;
        sp_if.rda = 1'b1;
        sp_if.tbr = 1'b1;
        @(negedge clk); expect_bus("mid_rd", 1, 1, 2'b00, 8'h00, 1);
        sp_if.rda = 1'b0;
        @(negedge clk); expect_bus("mid_wait", 0, 1, 2'b00, 8'h00, 1);
        @(negedge clk); expect_bus("mid_wr", 1, 0, 2'b00, 8'h33, 1);
        rst = 1'b0;
        #1;
        expect_reset("rst_mid_wr");
        reset_cfg(2'b11, 8'h50, 8'h00);

        // 256 random echoes from a fresh count must wrap echo_cnt back to zero.
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                nb = cur_br ^ 2'($urandom_range(1, 3));
                reconfig(nb, 1'b1, b);
            end else begin
                echo(b, ref_echo(b), int'($urandom_range(0, 3)));
            end
        end
        chk("echo_cnt_wrap", 32'(echo_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
